// File: rtl/raifes_uart_pkg.sv
// Shared definitions for the raifes UART transmit arbiter: FSM encoding,
// tag prefix used when RAIFES_UART_ARB_TAG_EN is defined, and default timeout.
package raifes_uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    STROBE    = 2'b01,
    WAIT_BUSY = 2'b10,
    WAIT_DONE = 2'b11
  } arb_state_t;

  localparam logic [7:0] TAG_PREFIX           = 8'hA0;
  localparam int         DEFAULT_BUSY_TIMEOUT = 4;

endpackage

// File: rtl/raifes_rr_pick.sv
// Combinational round-robin selector: first set bit of valid searching upward
// from (ptr+1) mod N, wrapping. Reusable for any shared peripheral.
module raifes_rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  int c;

  // Walk from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = 0;
    for (int k = N; k >= 1; k--) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (valid[c[IDW-1:0]]) begin
        found = 1'b1;
        idx   = c[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/raifes_uart_tx_arbiter.sv
// Round-robin arbiter sharing one raifes UART transmitter between NUM_REQ byte
// producers. Define RAIFES_UART_ARB_TAG_EN to prefix each byte with 8'hA0|grant_id.
module raifes_uart_tx_arbiter
  import raifes_uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int IDW          = 2,
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  input  logic                 tx_ready,
  output logic [7:0]           tx_sdata,
  output logic                 tx_send_strobe,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 err_timeout,
  output logic [1:0]           state_dbg
);

  // Handshake: requester i holds req_valid[i] and its byte stable until it
  // sees req_ack[i] (one cycle, coincident with tx_send_strobe); the core is
  // only strobed while tx_ready=1 and is considered done when tx_ready rises again.

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] ptr_q, grant_q, pick_idx;
  logic [7:0]     sdata_q;
  logic [CW-1:0]  cnt_q;
  logic           err_q, pick_found;
  logic           load_grant, cnt_inc, set_err, ack_phase;
  logic [7:0]     req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  raifes_rr_pick #(.N(NUM_REQ), .IDW(IDW)) u_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef RAIFES_UART_ARB_TAG_EN
  logic phase_q;       // 0 = tag byte in flight, 1 = payload byte in flight
  logic load_payload;
  assign ack_phase = phase_q;
`else
  assign ack_phase = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_grant = 1'b0;
    cnt_inc    = 1'b0;
    set_err    = 1'b0;
`ifdef RAIFES_UART_ARB_TAG_EN
    load_payload = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (tx_ready && pick_found) begin
          load_grant = 1'b1;
          state_d    = STROBE;
        end
      end
      STROBE: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        // The core drops tx_ready a cycle after the strobe; a high here is lag, not completion.
        if (!tx_ready) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          set_err = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          state_d = IDLE;
`ifdef RAIFES_UART_ARB_TAG_EN
          if (!phase_q) begin
            load_payload = 1'b1;
            state_d      = STROBE;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= IDW'(NUM_REQ - 1);
      grant_q <= '0;
      sdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (load_grant) begin
        ptr_q   <= pick_idx;
        grant_q <= pick_idx;
`ifdef RAIFES_UART_ARB_TAG_EN
        sdata_q <= TAG_PREFIX | {{(8-IDW){1'b0}}, pick_idx};
`else
        sdata_q <= req_bytes[pick_idx];
`endif
      end
`ifdef RAIFES_UART_ARB_TAG_EN
      if (load_payload) sdata_q <= req_bytes[grant_q];
`endif
      if (state_q == STROBE) cnt_q <= '0;
      else if (cnt_inc)      cnt_q <= cnt_q + 1'b1;
      if (set_err) err_q <= 1'b1;
    end
  end

`ifdef RAIFES_UART_ARB_TAG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          phase_q <= 1'b0;
    else if (load_grant)   phase_q <= 1'b0;
    else if (load_payload) phase_q <= 1'b1;
  end
`endif

  always_comb begin
    req_ack = '0;
    if (state_q == STROBE && ack_phase) req_ack[grant_q] = 1'b1;
  end

  assign tx_send_strobe = (state_q == STROBE);
  assign tx_sdata       = sdata_q;
  assign grant_id       = grant_q;
  assign busy           = (state_q != IDLE);
  assign err_timeout    = err_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_raifes_uart_tx_arbiter.sv
// Self-checking bench for raifes_uart_tx_arbiter with a behavioural UART core
// model; also valid when RAIFES_UART_ARB_TAG_EN is defined.
module tb_raifes_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int IDW          = 2;
  localparam int BUSY_TIMEOUT = 4;
  localparam int W            = NUM_REQ + IDW + 8;
  localparam int FRAME        = 10;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic                 tx_ready;
  logic [7:0]           tx_sdata;
  logic                 tx_send_strobe;
  logic [IDW-1:0]       grant_id;
  logic                 busy;
  logic                 err_timeout;
  logic [1:0]           state_dbg;

  // scoreboard: {req_ack, grant_id, tx_sdata} expected at each strobe
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int acks  = 0;
  bit done  = 1'b0;

  // core model controls: 0 = normal frame, 1 = never busy, 2 = manual ready
  int   core_mode    = 0;
  logic manual_ready = 1'b1;
  bit   lag          = 1'b0;
  int   frame_cnt    = 0;
  bit   keep_valid   = 1'b0;

  always #5 clk = ~clk;

  raifes_uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .IDW(IDW), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ack        (req_ack),
    .tx_ready       (tx_ready),
    .tx_sdata       (tx_sdata),
    .tx_send_strobe (tx_send_strobe),
    .grant_id       (grant_id),
    .busy           (busy),
    .err_timeout    (err_timeout),
    .state_dbg      (state_dbg)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push_tag(input int id);
    exp_q.push_back({{NUM_REQ{1'b0}}, IDW'(id), 8'hA0 | 8'(id)});
  endtask

  task automatic expect_byte(input int id, input logic [7:0] d);
    logic [NUM_REQ-1:0] oh;
    oh = NUM_REQ'(1) << id;
`ifdef RAIFES_UART_ARB_TAG_EN
    push_tag(id);
`endif
    exp_q.push_back({oh, IDW'(id), d});
  endtask

  // One cycle: advance to the falling edge, then update core and requester models.
  task automatic tick();
    @(negedge clk);
    case (core_mode)
      0: begin
        if (frame_cnt > 0) begin
          frame_cnt--;
          if (frame_cnt == 0) tx_ready = 1'b1;
        end
        if (lag) begin
          lag       = 1'b0;
          tx_ready  = 1'b0;
          frame_cnt = FRAME;
        end
        if (tx_send_strobe) lag = 1'b1;
      end
      1: begin
        tx_ready = 1'b1; lag = 1'b0; frame_cnt = 0;
      end
      default: begin
        tx_ready = manual_ready; lag = 1'b0; frame_cnt = 0;
      end
    endcase
    if (req_ack != '0) acks++;
    if (!keep_valid) req_valid = req_valid & ~req_ack;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check(name, (n < budget), 1);
  endtask

  task automatic monitor_loop();
    logic [W-1:0] got, exp;
    while (!done) begin
      @(negedge clk);
      if (tx_send_strobe) begin
        got = {req_ack, grant_id, tx_sdata};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL strobe_unexpected got=%h", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            bad++;
            $display("FAIL strobe got=%h exp=%h", got, exp);
          end
        end
      end else if (req_ack != '0) begin
        total++;
        bad++;
        $display("FAIL ack_without_strobe got=%h exp=0", req_ack);
      end
    end
  endtask

  task automatic run_tests();
    int n, base;

    // reset state
    repeat (3) tick();
    #1;
    check("rst_busy", busy, 0);
    check("rst_strobe", tx_send_strobe, 0);
    check("rst_ack", req_ack, 0);
    check("rst_sdata", tx_sdata, 0);
    check("rst_grant", grant_id, 0);
    check("rst_err", err_timeout, 0);
    check("rst_state", state_dbg, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // single request from requester 2
    req_data[23:16] = 8'h41;
    expect_byte(2, 8'h41);
    req_valid = 4'b0100;
    n = 0;
    while (!tx_send_strobe && n < 8) begin tick(); n++; end
    check("single_latency", n, 1);
    check("single_grant", grant_id, 2);
    check("single_busy", busy, 1);
    repeat (6) tick();
    check("single_busy_mid_frame", busy, 1);
    wait_idle("single_done", 80);
    check("single_idle", busy, 0);

    // blocked start: core not ready
    core_mode = 2; manual_ready = 1'b0;
    tick();
    req_data[7:0] = 8'h11;
    req_valid = 4'b0001;
    base = acks;
    repeat (8) tick();
    check("blocked_no_ack", acks - base, 0);
    check("blocked_idle", busy, 0);
    expect_byte(0, 8'h11);
    core_mode = 0;
    tx_ready  = 1'b1;
    n = 0;
    while (!tx_send_strobe && n < 6) begin tick(); n++; end
    check("blocked_strobe_within_2", (n >= 1 && n <= 2), 1);
    wait_idle("blocked_done", 80);

    // core never goes busy
    core_mode = 1;
    req_data[15:8] = 8'h5A;
`ifdef RAIFES_UART_ARB_TAG_EN
    push_tag(1);
`else
    expect_byte(1, 8'h5A);
`endif
    req_valid = 4'b0010;
    n = 0;
    while (!tx_send_strobe && n < 8) begin tick(); n++; end
    check("timeout_strobe_seen", tx_send_strobe, 1);
    n = 0;
    while (!err_timeout && n < 12) begin tick(); n++; end
    check("timeout_flag", err_timeout, 1);
    check("timeout_latency", (n <= BUSY_TIMEOUT + 1), 1);
    check("timeout_back_idle", busy, 0);
    core_mode = 0;
`ifdef RAIFES_UART_ARB_TAG_EN
    expect_byte(1, 8'h5A);
`endif
    wait_idle("timeout_recover", 80);
    req_data[23:16] = 8'h62;
    expect_byte(2, 8'h62);
    req_valid = 4'b0100;
    wait_idle("after_timeout_served", 80);
    check("err_sticky", err_timeout, 1);

    // reset mid-frame
    req_data[31:24] = 8'h77;
    expect_byte(3, 8'h77);
    req_valid = 4'b1000;
    base = acks;
    n = 0;
    while (!(acks > base && state_dbg == 2'd3) && n < 60) begin tick(); n++; end
    check("midframe_reached", state_dbg, 3);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_err", err_timeout, 0);
    check("midrst_sdata", tx_sdata, 0);
    check("midrst_grant", grant_id, 0);
    check("midrst_state", state_dbg, 0);
    tick();
    reset_n = 1'b1;

    // fairness after reset: requester 0 first, then strict rotation
    keep_valid = 1'b1;
    req_data = {8'h33, 8'h32, 8'h31, 8'h30};
    expect_byte(0, 8'h30);
    expect_byte(1, 8'h31);
    expect_byte(2, 8'h32);
    expect_byte(3, 8'h33);
    expect_byte(0, 8'h30);
    req_valid = 4'b1111;
    base = acks;
    n = 0;
    while (acks < base + 5 && n < 300) begin tick(); n++; end
    req_valid  = '0;
    keep_valid = 1'b0;
    check("fair_five_grants", acks - base, 5);
    wait_idle("fair_done", 80);
    check("fair_err_clear", err_timeout, 0);
    tick();
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
    fork
      monitor_loop();
      begin
        run_tests();
        done = 1'b1;
      end
    join
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
